// File: rtl/naive_bus_router_if.sv
// Naive-bus bundle of N ports: read/write request, grant, address and data.
// The bus master drives requests; the bus slave answers with grants and read data.
interface naive_bus_router_if #(
    parameter int N = 1
);
    logic [N-1:0]       rd_req;
    logic [N-1:0]       rd_gnt;
    logic [N-1:0][31:0] rd_addr;
    logic [N-1:0][31:0] rd_data;
    logic [N-1:0]       wr_req;
    logic [N-1:0]       wr_gnt;
    logic [N-1:0][31:0] wr_addr;
    logic [N-1:0][31:0] wr_data;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/naive_bus_router.sv
// Address-decoded N_MASTER x N_SLAVE naive-bus crossbar, fixed priority (master 0 highest).
// Define NAIVE_BUS_ROUTER_RR_ARB_EN to arbitrate each slave round-robin instead.
module naive_bus_router #(
    parameter int                         N_MASTER   = 2,
    parameter int                         N_SLAVE    = 4,
    parameter logic [N_SLAVE-1:0][31:0]   SLAVE_BASE = {32'h0003_0000, 32'h0002_0000,
                                                        32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLAVE-1:0][31:0]   SLAVE_MASK = {N_SLAVE{32'hFFFF_0000}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    naive_bus_router_if.slave    m_bus,
    naive_bus_router_if.master   s_bus
);
    localparam int MW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int SW = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

    logic [N_MASTER-1:0]         act_valid;
    logic [N_MASTER-1:0]         act_rd;
    logic [N_MASTER-1:0]         mapped;
    logic [N_MASTER-1:0][31:0]   act_addr;
    logic [N_MASTER-1:0][SW-1:0] tgt;
    logic [N_SLAVE-1:0]          win_valid;
    logic [N_SLAVE-1:0][MW-1:0]  win_idx;
    logic [N_MASTER-1:0]         rd_gnt;
    logic [N_MASTER-1:0]         wr_gnt;

    logic [N_MASTER-1:0]         ret_valid_q, ret_valid_d;
    logic [N_MASTER-1:0]         ret_hit_q, ret_hit_d;
    logic [N_MASTER-1:0][SW-1:0] ret_slave_q, ret_slave_d;

`ifdef NAIVE_BUS_ROUTER_RR_ARB_EN
    logic [N_SLAVE-1:0][MW-1:0]  ptr_q, ptr_d;
`endif

    // A read masks a simultaneous write, so each master has one active transaction.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        act_valid = '0;
        act_rd    = '0;
        act_addr  = '0;
        mapped    = '0;
        tgt       = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            act_rd[i]    = m_bus.rd_req[i];
            act_valid[i] = m_bus.rd_req[i] | m_bus.wr_req[i];
            act_addr[i]  = m_bus.rd_req[i] ? m_bus.rd_addr[i] : m_bus.wr_addr[i];
            // Descending scan: the lowest matching slave is written last and wins.
            for (int j = N_SLAVE - 1; j >= 0; j--) begin
                if ((act_addr[i] & SLAVE_MASK[j]) == SLAVE_BASE[j]) begin
                    mapped[i] = 1'b1;
                    tgt[i]    = SW'(j);
                end
            end
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        win_valid = '0;
        win_idx   = '0;
        for (int j = 0; j < N_SLAVE; j++) begin
            // Scan from lowest to highest priority so the highest-priority hit lands last.
            for (int k = N_MASTER - 1; k >= 0; k--) begin
`ifdef NAIVE_BUS_ROUTER_RR_ARB_EN
                idx = (int'(ptr_q[j]) + k) % N_MASTER;
`else
                idx = k;
`endif
                if (act_valid[idx] && mapped[idx] && tgt[idx] == SW'(j)) begin
                    win_valid[j] = 1'b1;
                    win_idx[j]   = MW'(idx);
                end
            end
        end
    end

    always_comb begin
        s_bus.rd_req  = '0;
        s_bus.rd_addr = '0;
        s_bus.wr_req  = '0;
        s_bus.wr_addr = '0;
        s_bus.wr_data = '0;
        for (int j = 0; j < N_SLAVE; j++) begin
            if (win_valid[j]) begin
                if (act_rd[win_idx[j]]) begin
                    s_bus.rd_req[j]  = 1'b1;
                    s_bus.rd_addr[j] = act_addr[win_idx[j]];
                end else begin
                    s_bus.wr_req[j]  = 1'b1;
                    s_bus.wr_addr[j] = act_addr[win_idx[j]];
                    s_bus.wr_data[j] = m_bus.wr_data[win_idx[j]];
                end
            end
        end
    end

    // Unmapped accesses complete at once; losers see gnt=0 and simply retry.
    always_comb begin
        logic g;
        g      = 1'b0;
        rd_gnt = '0;
        wr_gnt = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (!mapped[i]) begin
                g = 1'b1;
            end else if (win_valid[tgt[i]] && win_idx[tgt[i]] == MW'(i)) begin
                g = act_rd[i] ? s_bus.rd_gnt[tgt[i]] : s_bus.wr_gnt[tgt[i]];
            end else begin
                g = 1'b0;
            end
            rd_gnt[i] = act_rd[i] & g;
            wr_gnt[i] = act_valid[i] & ~act_rd[i] & g;
        end
    end

    assign m_bus.rd_gnt = rd_gnt;
    assign m_bus.wr_gnt = wr_gnt;

    always_comb begin
        ret_valid_d = rd_gnt;
        ret_hit_d   = rd_gnt & mapped;
        ret_slave_d = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (rd_gnt[i]) ret_slave_d[i] = tgt[i];
        end
    end

    always_comb begin
        m_bus.rd_data = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (ret_valid_q[i] && ret_hit_q[i]) m_bus.rd_data[i] = s_bus.rd_data[ret_slave_q[i]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_valid_q <= '0;
            ret_hit_q   <= '0;
            ret_slave_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from pre-edge values.
            ret_valid_q <= ret_valid_d;
            ret_hit_q   <= ret_hit_d;
            ret_slave_q <= ret_slave_d;
        end
    end

`ifdef NAIVE_BUS_ROUTER_RR_ARB_EN
    // The master that just completed on a slave drops to lowest priority there.
    always_comb begin
        ptr_d = ptr_q;
        for (int j = 0; j < N_SLAVE; j++) begin
            if (win_valid[j] &&
                (act_rd[win_idx[j]] ? s_bus.rd_gnt[j] : s_bus.wr_gnt[j])) begin
                ptr_d[j] = MW'((int'(win_idx[j]) + 1) % N_MASTER);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif
endmodule

// File: tb/tb_naive_bus_router.sv
// Self-checking bench for naive_bus_router: direct checks on grants/slave drive plus a
// scoreboard of expected read-return data popped one cycle after each read is issued.
module tb_naive_bus_router;
    localparam int NM = 2;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    naive_bus_router_if #(.N(NM)) m_if ();
    naive_bus_router_if #(.N(NS)) s_if ();

    naive_bus_router #(.N_MASTER(NM), .N_SLAVE(NS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m_bus (m_if),
        .s_bus (s_if)
    );

    typedef struct {
        int          due;
        int          m;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc;
    int          n_tests;
    int          n_fail;
    logic [31:0] slave_val [NS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_rd(input int m, input logic [31:0] data, input string tag);
        exp_t e;
        e.due  = cyc + 1;
        e.m    = m;
        e.data = data;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        m_if.rd_req  = '0;
        m_if.wr_req  = '0;
        m_if.rd_addr = '0;
        m_if.wr_addr = '0;
        m_if.wr_data = '0;
    endtask

    // Slave model: read data for a handshaked request appears the next cycle;
    // otherwise the bus carries junk that must never reach a master.
    task automatic slave_respond(input logic [NS-1:0] hs);
        for (int j = 0; j < NS; j++)
            s_if.rd_data[j] = hs[j] ? slave_val[j] : (32'hBAD0_0000 | 32'(j));
    endtask

    task automatic tick();
        logic [NS-1:0] hs;
        exp_t e;
        hs = s_if.rd_req & s_if.rd_gnt;
        @(posedge clk);
        cyc++;
        slave_respond(hs);
        #1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check(e.tag, m_if.rd_data[e.m], e.data);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        idle();
        s_if.rd_gnt = '1;
        s_if.wr_gnt = '1;
        for (int j = 0; j < NS; j++) slave_val[j] = 32'h5000_0000 | 32'(j);
        slave_respond('0);

        // Reset: no requests, every output quiet.
        @(negedge clk);
        @(negedge clk);
        check("rst_m_rd_gnt", 32'(m_if.rd_gnt), 32'h0);
        check("rst_m_wr_gnt", 32'(m_if.wr_gnt), 32'h0);
        check("rst_m_rd_data0", m_if.rd_data[0], 32'h0);
        check("rst_m_rd_data1", m_if.rd_data[1], 32'h0);
        check("rst_s_rd_req", 32'(s_if.rd_req), 32'h0);
        check("rst_s_wr_req", 32'(s_if.wr_req), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read m0 -> slave 1.
        idle();
        m_if.rd_req[0]  = 1'b1;
        m_if.rd_addr[0] = 32'h0001_0004;
        slave_val[1]    = 32'h1234_5678;
        #1;
        check("single_gnt", 32'(m_if.rd_gnt), 32'h1);
        check("single_s_req", 32'(s_if.rd_req), 32'h2);
        check("single_s_addr", s_if.rd_addr[1], 32'h0001_0004);
        expect_rd(0, 32'h1234_5678, "single_data_m0");
        expect_rd(1, 32'h0, "single_data_m1");
        tick();
        idle();
        #1;
        expect_rd(0, 32'h0, "single_ret_clear");
        tick();

        // Contention on slave 0 for 3 cycles.
        for (int k = 0; k < 3; k++) begin
`ifdef NAIVE_BUS_ROUTER_RR_ARB_EN
            w = k % 2;
`else
            w = 0;
`endif
            idle();
            m_if.rd_req     = 2'b11;
            m_if.rd_addr[0] = 32'h0000_0100;
            m_if.rd_addr[1] = 32'h0000_0200;
            slave_val[0]    = 32'hC0DE_0000 + 32'(k);
            #1;
            check("cont_gnt", 32'(m_if.rd_gnt), 32'(1 << w));
            check("cont_s_addr", s_if.rd_addr[0], (w == 0) ? 32'h0000_0100 : 32'h0000_0200);
            expect_rd(w, 32'hC0DE_0000 + 32'(k), "cont_data_win");
            expect_rd(1 - w, 32'h0, "cont_data_lose");
            tick();
        end

        // Parallel: m1 fetches slave 0 while m0 writes slave 2.
        idle();
        m_if.rd_req[1]  = 1'b1;
        m_if.rd_addr[1] = 32'h0000_0010;
        m_if.wr_req[0]  = 1'b1;
        m_if.wr_addr[0] = 32'h0002_0000;
        m_if.wr_data[0] = 32'hA5A5_A5A5;
        slave_val[0]    = 32'h0F0F_1234;
        #1;
        check("par_rd_gnt", 32'(m_if.rd_gnt), 32'h2);
        check("par_wr_gnt", 32'(m_if.wr_gnt), 32'h1);
        check("par_s_rd_req", 32'(s_if.rd_req), 32'h1);
        check("par_s_wr_req", 32'(s_if.wr_req), 32'h4);
        check("par_s_wr_data", s_if.wr_data[2], 32'hA5A5_A5A5);
        check("par_s_wr_addr", s_if.wr_addr[2], 32'h0002_0000);
        expect_rd(1, 32'h0F0F_1234, "par_data_m1");
        expect_rd(0, 32'h0, "par_data_m0");
        tick();

        // Unmapped read and write.
        idle();
        m_if.rd_req[0]  = 1'b1;
        m_if.rd_addr[0] = 32'hF000_0000;
        m_if.wr_req[1]  = 1'b1;
        m_if.wr_addr[1] = 32'hF000_0000;
        m_if.wr_data[1] = 32'hDEAD_DEAD;
        #1;
        check("unm_rd_gnt", 32'(m_if.rd_gnt), 32'h1);
        check("unm_wr_gnt", 32'(m_if.wr_gnt), 32'h2);
        check("unm_s_rd_req", 32'(s_if.rd_req), 32'h0);
        check("unm_s_wr_req", 32'(s_if.wr_req), 32'h0);
        expect_rd(0, 32'h0, "unm_data");
        tick();

        // Slave 3 stalls writes for 2 cycles.
        idle();
        m_if.wr_req[0]  = 1'b1;
        m_if.wr_addr[0] = 32'h0003_0040;
        m_if.wr_data[0] = 32'h0000_55AA;
        s_if.wr_gnt[3]  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("stall_wr_gnt", 32'(m_if.wr_gnt), 32'h0);
            check("stall_s_wr_req", 32'(s_if.wr_req), 32'h8);
            tick();
        end
        s_if.wr_gnt[3] = 1'b1;
        #1;
        check("stall_release_gnt", 32'(m_if.wr_gnt), 32'h1);
        check("stall_s_wr_data", s_if.wr_data[3], 32'h0000_55AA);
        tick();

        // Read beats a simultaneous write on the same master.
        idle();
        m_if.rd_req[0]  = 1'b1;
        m_if.rd_addr[0] = 32'h0001_0008;
        m_if.wr_req[0]  = 1'b1;
        m_if.wr_addr[0] = 32'h0002_0004;
        m_if.wr_data[0] = 32'h1111_2222;
        slave_val[1]    = 32'h7777_0001;
        #1;
        check("rw_rd_gnt", 32'(m_if.rd_gnt), 32'h1);
        check("rw_wr_gnt", 32'(m_if.wr_gnt), 32'h0);
        check("rw_s_wr_req", 32'(s_if.wr_req), 32'h0);
        check("rw_s_rd_req", 32'(s_if.rd_req), 32'h2);
        expect_rd(0, 32'h7777_0001, "rw_data");
        tick();

        // Back-to-back reads from m0 to different slaves.
        idle();
        m_if.rd_req[0]  = 1'b1;
        m_if.rd_addr[0] = 32'h0002_0000;
        slave_val[2]    = 32'h2222_0002;
        #1;
        expect_rd(0, 32'h2222_0002, "b2b_data_1");
        tick();
        m_if.rd_addr[0] = 32'h0003_0004;
        slave_val[3]    = 32'h3333_0003;
        #1;
        expect_rd(0, 32'h3333_0003, "b2b_data_2");
        tick();

        // Reset asserted the cycle after a granted read: the return must be squashed.
        idle();
        m_if.rd_req[0]  = 1'b1;
        m_if.rd_addr[0] = 32'h0000_0010;
        slave_val[0]    = 32'hFEED_BEEF;
        #1;
        check("rstmid_gnt", 32'(m_if.rd_gnt), 32'h1);
        begin
            logic [NS-1:0] hs;
            hs = s_if.rd_req & s_if.rd_gnt;
            @(posedge clk);
            slave_respond(hs);
        end
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        check("rstmid_data", m_if.rd_data[0], 32'h0);
        check("rstmid_m_rd_gnt", 32'(m_if.rd_gnt), 32'h0);
        check("rstmid_s_rd_req", 32'(s_if.rd_req), 32'h0);
        check("rstmid_s_rd_addr", s_if.rd_addr[0], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // After reset, contention on slave 0 starts from master 0 in either build.
        idle();
        m_if.rd_req     = 2'b11;
        m_if.rd_addr[0] = 32'h0000_0300;
        m_if.rd_addr[1] = 32'h0000_0400;
        slave_val[0]    = 32'hABCD_0001;
        #1;
        check("post_rst_gnt", 32'(m_if.rd_gnt), 32'h1);
        expect_rd(0, 32'hABCD_0001, "post_rst_data");
        tick();
        idle();
        #1;
        tick();

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
